// File: rtl/pwm_ctrl_pkg.sv
// rtl/pwm_ctrl_pkg.sv - shared types and constants for the PWM fade controller
package pwm_ctrl_pkg;

  localparam int DUTY_W           = 8;
  localparam int CLK_DIV_TRIG_DEF = 12;
  localparam int PWM_STEPS        = 1 << DUTY_W;
  localparam int PERIOD_CLKS_DEF  = (CLK_DIV_TRIG_DEF + 1) * PWM_STEPS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } fade_state_t;

  // A zero step or interval would stall the fade, so it is promoted to one.
  function automatic logic [DUTY_W-1:0] at_least_one(input logic [DUTY_W-1:0] v);
    return (v == '0) ? DUTY_W'(1) : v;
  endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// rtl/pwm_period_timer.sv - free-running prescaler and 8-bit PWM period counter
// Mirrors the PWM output stage counter so period_tick marks its last clk of a period.
module pwm_period_timer
  import pwm_ctrl_pkg::*;
#(
  parameter int CLK_DIV_TRIG = CLK_DIV_TRIG_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic period_tick
);

  localparam int CW = (CLK_DIV_TRIG > 0) ? $clog2(CLK_DIV_TRIG + 1) : 1;

  logic [CW-1:0]     clk_cnt;
  logic [DUTY_W-1:0] pwm_cnt;
  logic              clk_term;

  assign clk_term = (clk_cnt == CW'(CLK_DIV_TRIG));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt <= '0;
      pwm_cnt <= '0;
    end else if (clk_term) begin
      clk_cnt <= '0;
      pwm_cnt <= pwm_cnt + 1'b1;
    end else begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

  assign period_tick = clk_term && (pwm_cnt == '1);

endmodule

// File: rtl/pwm_fade_ctrl.sv
// rtl/pwm_fade_ctrl.sv - ramps the PWM duty toward a commanded target on period boundaries
// Optional breathing mode is built when PWM_FADE_LOOP_EN is defined.
module pwm_fade_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int CLK_DIV_TRIG = CLK_DIV_TRIG_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_target,
  input  logic [DUTY_W-1:0] cmd_step,
  input  logic [DUTY_W-1:0] cmd_interval,
  input  logic              cmd_loop,
  input  logic              abort,
  output logic [DUTY_W-1:0] duty,
  output logic              period_tick,
  output logic              busy,
  output logic              done
);

  fade_state_t       state, state_nxt;
  logic [DUTY_W-1:0] duty_q, target_q, step_q, ivl_q, ivl_cnt;
  logic [DUTY_W-1:0] step_duty;
  logic [DUTY_W:0]   diff;
  logic              going_up, accept, step_now, reached, loop_active;

  pwm_period_timer #(
    .CLK_DIV_TRIG(CLK_DIV_TRIG)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .period_tick(period_tick)
  );

`ifdef PWM_FADE_LOOP_EN
  logic              loop_q;
  logic [DUTY_W-1:0] start_q;
  assign loop_active = loop_q;
`else
  logic unused_cmd_loop;
  assign unused_cmd_loop = cmd_loop;
  assign loop_active     = 1'b0;
`endif

  assign accept   = (state == ST_IDLE) && cmd_valid;
  assign step_now = (state == ST_WAIT) && !abort && period_tick && (ivl_cnt == DUTY_W'(1));
  assign reached  = (duty_q == target_q);

  // Saturate at the target so a large step never overshoots it.
  always_comb begin
    going_up  = (target_q > duty_q);
    diff      = going_up ? ({1'b0, target_q} - {1'b0, duty_q})
                         : ({1'b0, duty_q} - {1'b0, target_q});
    step_duty = duty_q;
    if (diff <= {1'b0, step_q}) begin
      step_duty = target_q;
    end else if (going_up) begin
      step_duty = duty_q + step_q;
    end else begin
      step_duty = duty_q - step_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_nxt = (cmd_target == duty_q) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (period_tick && (ivl_cnt == DUTY_W'(1))) begin
          state_nxt = ST_STEP;
        end
      end
      ST_STEP: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (reached && !loop_active) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE) && !abort;
  end

  // The new duty is registered on the tick edge so it lands as pwm_cnt wraps to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q   <= '0;
      target_q <= '0;
      step_q   <= '0;
      ivl_q    <= '0;
      ivl_cnt  <= '0;
    end else begin
      if (accept) begin
        target_q <= cmd_target;
        step_q   <= at_least_one(cmd_step);
        ivl_q    <= at_least_one(cmd_interval);
        ivl_cnt  <= at_least_one(cmd_interval);
      end else if (step_now) begin
        duty_q <= step_duty;
      end else if ((state == ST_WAIT) && !abort && period_tick) begin
        ivl_cnt <= ivl_cnt - 1'b1;
      end else if ((state == ST_STEP) && !abort) begin
        ivl_cnt <= ivl_q;
`ifdef PWM_FADE_LOOP_EN
        if (reached && loop_q) begin
          target_q <= start_q;
        end
`endif
      end
    end
  end

`ifdef PWM_FADE_LOOP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loop_q  <= 1'b0;
      start_q <= '0;
    end else if (accept) begin
      loop_q  <= cmd_loop;
      start_q <= duty_q;
    end else if ((state == ST_STEP) && !abort && reached && loop_q) begin
      start_q <= target_q;
    end
  end
`endif

  assign duty = duty_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb/tb_pwm_fade_ctrl.sv - randomized self-checking bench for pwm_fade_ctrl
module tb_pwm_fade_ctrl;

  localparam int TRIG = 1;
  localparam int PER  = (TRIG + 1) * 256;

  logic       clk, rst_n;
  logic       cmd_valid, cmd_ready, cmd_loop, abort;
  logic [7:0] cmd_target, cmd_step, cmd_interval, duty;
  logic       period_tick, busy, done;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_duty = 8'd0;
  logic [7:0] exp_q[$];

  pwm_fade_ctrl #(.CLK_DIV_TRIG(TRIG)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_target  (cmd_target),
    .cmd_step    (cmd_step),
    .cmd_interval(cmd_interval),
    .cmd_loop    (cmd_loop),
    .abort       (abort),
    .duty        (duty),
    .period_tick (period_tick),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: list of duty values a fade visits, from plain arithmetic.
  function automatic void build_exp(input int d, input int t, input int s);
    int se;
    se = (s == 0) ? 1 : s;
    exp_q.delete();
    while (d != t) begin
      if (((t > d) ? t - d : d - t) <= se) d = t;
      else if (t > d) d = d + se;
      else d = d - se;
      exp_q.push_back(8'(d));
    end
  endfunction

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] t, input logic [7:0] s, input logic [7:0] i,
                          input logic l, input logic ab);
    @(negedge clk);
    cmd_target = t; cmd_step = s; cmd_interval = i; cmd_loop = l;
    cmd_valid = 1'b1; abort = ab;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; abort = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
  endtask

  task automatic run_fade(input logic [7:0] t, input logic [7:0] s, input logic [7:0] i,
                          input logic l);
    int ivl, idx, ticks, since, dones, budget;
    logic [7:0] prev;
    bit got_done;
    build_exp(int'(model_duty), int'(t), int'(s));
    ivl = (i == 0) ? 1 : int'(i);
    send_cmd(t, s, i, l, 1'b0);
    if (exp_q.size() == 0) begin
      got_done = done;
      if (!got_done) begin
        sample();
        got_done = done;
      end
      checks++;
      if (got_done !== 1'b1) begin
        errors++; $display("FAIL same_target_done: done=%0b expected 1", got_done);
      end
      checks++;
      if (duty !== model_duty) begin
        errors++; $display("FAIL same_target_duty: duty=%0d expected %0d", duty, model_duty);
      end
    end else begin
      prev = model_duty; idx = 0; ticks = 0; since = 1000; dones = 0;
      budget = (exp_q.size() * ivl + 2) * PER;
      for (int c = 0; c < budget && idx < exp_q.size(); c++) begin
        if (c > 0) sample();
        since++;
        if (done === 1'b1) dones++;
        if (duty !== prev) begin
          checks++;
          if (duty !== exp_q[idx]) begin
            errors++; $display("FAIL step_value[%0d]: duty=%0d expected %0d", idx, duty, exp_q[idx]);
          end
          checks++;
          if (ticks != ivl || since != 1) begin
            errors++;
            $display("FAIL step_timing[%0d]: ticks=%0d clk_after_tick=%0d expected %0d and 1",
                     idx, ticks, since, ivl);
          end
          prev = duty; ticks = 0; idx++;
        end
        if (period_tick === 1'b1) begin
          ticks++; since = 0;
        end
      end
      checks++;
      if (idx != exp_q.size()) begin
        errors++; $display("FAIL fade_timeout: steps=%0d expected %0d", idx, exp_q.size());
      end
      got_done = 1'b0;
      for (int k = 0; k < 3; k++) begin
        sample();
        if (done === 1'b1) begin
          dones++; got_done = 1'b1; break;
        end
      end
      checks++;
      if (!got_done || dones != 1) begin
        errors++; $display("FAIL done_pulse: pulses=%0d seen_at_end=%0b expected 1 and 1", dones, got_done);
      end
    end
    sample();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_fade: ready=%0b busy=%0b expected 1 0", cmd_ready, busy);
    end
    model_duty = t;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_loop = 1'b0; abort = 1'b0;
    cmd_target = '0; cmd_step = '0; cmd_interval = '0;
    #12;
    checks++;
    if (duty !== 8'd0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || period_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: duty=%0d ready=%0b busy=%0b done=%0b tick=%0b expected 0 1 0 0 0",
               duty, cmd_ready, busy, done, period_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sample();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || duty !== 8'd0) begin
      errors++; $display("FAIL after_release: ready=%0b busy=%0b duty=%0d expected 1 0 0", cmd_ready, busy, duty);
    end
    n = 0;
    while (period_tick !== 1'b1 && n < 2 * PER) begin
      sample(); n++;
    end
    n = 0;
    do begin
      sample(); n++;
    end while (period_tick !== 1'b1 && n < 2 * PER);
    checks++;
    if (n != PER) begin
      errors++; $display("FAIL tick_period: clks=%0d expected %0d", n, PER);
    end
  endtask

  task automatic test_ramp_up();
    run_fade(8'd100, 8'd10, 8'd1, 1'b0);
  endtask

  task automatic test_ramp_down();
    run_fade(8'd5, 8'd10, 8'd2, 1'b0);
  endtask

  task automatic test_zero_params();
    run_fade(8'd3, 8'd0, 8'd0, 1'b0);
    run_fade(8'd3, 8'd7, 8'd1, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] t, s, i;
    for (int n = 0; n < 6; n++) begin
      do begin
        t = 8'($urandom_range(0, 255));
        s = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        build_exp(int'(model_duty), int'(t), int'(s));
      end while (exp_q.size() > 4);
      i = 8'($urandom_range(0, 2));
      run_fade(t, s, i, 1'b0);
    end
  endtask

  task automatic test_abort();
    int changes, dones;
    run_fade(8'd40, 8'd255, 8'd1, 1'b0);
    send_cmd(8'd200, 8'd10, 8'd3, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL abort_fade_started: busy=%0b expected 1", busy);
    end
    repeat (PER / 2) sample();
    pulse_abort();
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || duty !== 8'd40 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_wait: busy=%0b ready=%0b duty=%0d done=%0b expected 0 1 40 0",
               busy, cmd_ready, duty, done);
    end
    changes = 0; dones = 0;
    for (int c = 0; c < 3 * PER; c++) begin
      sample();
      if (duty !== 8'd40) changes++;
      if (done === 1'b1) dones++;
    end
    checks++;
    if (changes != 0 || dones != 0) begin
      errors++; $display("FAIL abort_hold: duty_changes=%0d done_pulses=%0d expected 0 0", changes, dones);
    end
    send_cmd(8'd200, 8'd10, 8'd3, 1'b0, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL abort_with_cmd_idle: busy=%0b expected 1", busy);
    end
    pulse_abort();
    checks++;
    if (busy !== 1'b0 || duty !== 8'd40) begin
      errors++; $display("FAIL abort_second: busy=%0b duty=%0d expected 0 40", busy, duty);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    send_cmd(8'd200, 8'd50, 8'd1, 1'b0, 1'b0);
    n = 0;
    while (duty === 8'd40 && n < 2 * PER) begin
      sample(); n++;
    end
    checks++;
    if (duty !== 8'd90) begin
      errors++; $display("FAIL reset_mid_step: duty=%0d expected 90", duty);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (duty !== 8'd0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || period_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_values: duty=%0d ready=%0b busy=%0b done=%0b tick=%0b expected 0 1 0 0 0",
               duty, cmd_ready, busy, done, period_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_duty = 8'd0;
  endtask

`ifdef PWM_FADE_LOOP_EN
  task automatic test_loop();
    logic [7:0] loop_exp [0:5];
    logic [7:0] prev;
    int idx, dones;
    loop_exp = '{8'd10, 8'd20, 8'd10, 8'd0, 8'd10, 8'd20};
    send_cmd(8'd20, 8'd10, 8'd1, 1'b1, 1'b0);
    prev = 8'd0; idx = 0; dones = 0;
    for (int c = 0; c < 8 * PER && idx < 6; c++) begin
      if (c > 0) sample();
      if (done === 1'b1) dones++;
      if (duty !== prev) begin
        checks++;
        if (duty !== loop_exp[idx]) begin
          errors++; $display("FAIL loop_value[%0d]: duty=%0d expected %0d", idx, duty, loop_exp[idx]);
        end
        prev = duty; idx++;
      end
    end
    checks++;
    if (idx != 6 || dones != 0) begin
      errors++; $display("FAIL loop_sequence: steps=%0d done_pulses=%0d expected 6 0", idx, dones);
    end
    pulse_abort();
    checks++;
    if (busy !== 1'b0 || duty !== 8'd20 || done !== 1'b0) begin
      errors++; $display("FAIL loop_abort: busy=%0b duty=%0d done=%0b expected 0 20 0", busy, duty, done);
    end
    model_duty = 8'd20;
  endtask
`else
  task automatic test_loop();
    run_fade(8'd20, 8'd10, 8'd1, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_zero_params();
    test_random();
    test_abort();
    test_reset_mid();
    test_loop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
